// File: rtl/pcpi_dispatch.sv
// rtl/pcpi_dispatch.sv - PCPI request dispatcher for M-extension multiply/divide coprocessors
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pcpi_valid/insn/rs1/rs2         CPU request
//   pcpi_wr/rd/wait/ready           CPU response
//   mul_valid, div_valid            per-unit request strobes
//   co_insn, co_rs1, co_rs2         registered request shared by both units
//   mul_/div_ ready, wr, rd         per-unit completion
module pcpi_dispatch #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mul_valid,
  output logic        div_valid,
  output logic [31:0] co_insn,
  output logic [31:0] co_rs1,
  output logic [31:0] co_rs2,
  input  logic        mul_ready,
  input  logic        div_ready,
  input  logic        mul_wr,
  input  logic        div_wr,
  input  logic [31:0] mul_rd,
  input  logic [31:0] div_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

  // Last ISSUE cycle index; counter value TIMEOUT_CYCLES-1 means this is the final cycle.
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  tcnt;
  logic        sel_div;
  logic        lat_wr;
  logic        insn_match;
  logic        unit_ready;
  logic        accept;
  logic        take_result;

  assign insn_match  = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
  // Only the selected unit's ready is observed; the other unit is ignored.
  assign unit_ready  = sel_div ? div_ready : mul_ready;
  assign accept      = (state == IDLE) && pcpi_valid && insn_match;
  // CPU withdrawing the request has priority over a coincident ready.
  assign take_result = (state == ISSUE) && pcpi_valid && unit_ready;

  always_comb begin
    state_nxt  = state;
    mul_valid  = 1'b0;
    div_valid  = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        mul_valid = !sel_div;
        div_valid = sel_div;
        pcpi_wait = 1'b1;
        // Ready is checked before the timeout so a last-cycle completion is kept.
        if (!pcpi_valid)          state_nxt = IDLE;
        else if (unit_ready)      state_nxt = RESP;
        else if (tcnt == TLAST)   state_nxt = DRAIN;
      end
      RESP: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = lat_wr;
        state_nxt  = DRAIN;
      end
      DRAIN: begin
        if (!pcpi_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tcnt    <= 8'd0;
      sel_div <= 1'b0;
      lat_wr  <= 1'b0;
      pcpi_rd <= 32'd0;
      co_insn <= 32'd0;
      co_rs1  <= 32'd0;
      co_rs2  <= 32'd0;
    end else begin
      state <= state_nxt;
      // Cleared outside ISSUE, so it is zero on the first ISSUE cycle.
      tcnt  <= (state == ISSUE) ? tcnt + 8'd1 : 8'd0;
      if (accept) begin
        co_insn <= pcpi_insn;
        co_rs1  <= pcpi_rs1;
        co_rs2  <= pcpi_rs2;
        sel_div <= pcpi_insn[14];
      end
      if (take_result) begin
        lat_wr  <= sel_div ? div_wr : mul_wr;
        pcpi_rd <= sel_div ? div_rd : mul_rd;
      end
    end
  end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// tb/tb_pcpi_dispatch.sv - self-checking bench for pcpi_dispatch
module tb_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        mul_valid, div_valid;
  logic [31:0] co_insn, co_rs1, co_rs2;
  logic        mul_ready, div_ready, mul_wr, div_wr;
  logic [31:0] mul_rd, div_rd;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [31:0] rd;
    logic        wr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pcpi_dispatch #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mul_valid(mul_valid), .div_valid(div_valid),
    .co_insn(co_insn), .co_rs1(co_rs1), .co_rs2(co_rs2),
    .mul_ready(mul_ready), .div_ready(div_ready), .mul_wr(mul_wr), .div_wr(div_wr),
    .mul_rd(mul_rd), .div_rd(div_rd)
  );

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stubs();
    mul_ready = 1'b0; div_ready = 1'b0; mul_wr = 1'b0; div_wr = 1'b0;
  endtask

  // Drives one CPU request and a coprocessor stub that answers after lat valid cycles.
  task automatic do_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                        input bit use_div, input int lat, input logic [31:0] ret_rd, input logic ret_wr,
                        output int n_rdy, output logic [31:0] got_rd, output logic got_wr,
                        output int vcyc, output int other_v, output int rdy_at,
                        output logic [31:0] got_rs1, output logic [31:0] got_rs2);
    int done_c;
    done_c = -1; n_rdy = 0; vcyc = 0; other_v = 0; rdy_at = -1;
    got_rd = 32'd0; got_wr = 1'b0; got_rs1 = 32'd0; got_rs2 = 32'd0;
    pcpi_insn = insn; pcpi_rs1 = rs1; pcpi_rs2 = rs2; pcpi_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      clear_stubs();
      if (use_div ? mul_valid : div_valid) other_v++;
      if (use_div ? div_valid : mul_valid) begin
        vcyc++;
        if (vcyc == 1) begin got_rs1 = co_rs1; got_rs2 = co_rs2; end
        if (vcyc == lat) begin
          if (use_div) begin div_ready = 1'b1; div_wr = ret_wr; div_rd = ret_rd; end
          else         begin mul_ready = 1'b1; mul_wr = ret_wr; mul_rd = ret_rd; end
        end
      end
      if (pcpi_ready) begin
        n_rdy++;
        if (done_c < 0) begin done_c = c; rdy_at = c; got_rd = pcpi_rd; got_wr = pcpi_wr; end
      end
      if (done_c >= 0 && c == done_c + 1) pcpi_valid = 1'b0;
      if (done_c >= 0 && c == done_c + 2) break;
    end
    if (done_c < 0) begin
      pcpi_valid = 1'b0;
      clear_stubs();
      step(); step();
    end
  endtask

  task automatic run_and_check(input string nm, input logic [31:0] insn, input logic [31:0] rs1,
                               input logic [31:0] rs2, input bit use_div, input int lat,
                               input logic [31:0] ret_rd, input logic ret_wr);
    int n_rdy, vcyc, other_v, rdy_at;
    logic [31:0] got_rd, got_rs1, got_rs2;
    logic got_wr;
    exp_t e;
    exp_q.push_back('{rd: ret_rd, wr: ret_wr});
    do_txn(insn, rs1, rs2, use_div, lat, ret_rd, ret_wr, n_rdy, got_rd, got_wr, vcyc, other_v, rdy_at, got_rs1, got_rs2);
    e = exp_q.pop_front();
    tot_cnt++; if (n_rdy !== 1) $display("FAIL %s ready_pulses got=%0d exp=1", nm, n_rdy); else pass_cnt++;
    tot_cnt++; if (got_rd !== e.rd) $display("FAIL %s pcpi_rd got=%h exp=%h", nm, got_rd, e.rd); else pass_cnt++;
    tot_cnt++; if (got_wr !== e.wr) $display("FAIL %s pcpi_wr got=%b exp=%b", nm, got_wr, e.wr); else pass_cnt++;
    tot_cnt++; if (vcyc !== lat) $display("FAIL %s unit_valid_cycles got=%0d exp=%0d", nm, vcyc, lat); else pass_cnt++;
    tot_cnt++; if (other_v !== 0) $display("FAIL %s other_unit_valid got=%0d exp=0", nm, other_v); else pass_cnt++;
    tot_cnt++; if (rdy_at !== lat) $display("FAIL %s ready_latency got=%0d exp=%0d", nm, rdy_at, lat); else pass_cnt++;
    tot_cnt++; if ({got_rs1, got_rs2} !== {rs1, rs2}) $display("FAIL %s co_operands got=%h/%h exp=%h/%h", nm, got_rs1, got_rs2, rs1, rs2); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    tot_cnt++;
    if ({pcpi_wr, pcpi_ready, pcpi_wait, mul_valid, div_valid} !== 5'b0 || pcpi_rd !== 32'd0 ||
        co_insn !== 32'd0 || co_rs1 !== 32'd0 || co_rs2 !== 32'd0)
      $display("FAIL reset_outputs got=%b rd=%h co=%h", {pcpi_wr, pcpi_ready, pcpi_wait, mul_valid, div_valid}, pcpi_rd, co_insn);
    else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_mul();
    run_and_check("mul", mk_insn(7'b0000001, 3'b000), 32'd3, 32'd7, 1'b0, 4, 32'd21, 1'b1);
  endtask

  task automatic test_divu();
    run_and_check("divu", mk_insn(7'b0000001, 3'b101), 32'd100, 32'd7, 1'b1, 3, 32'd14, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_and_check("b2b_mul", mk_insn(7'b0000001, 3'b000), 32'd3, 32'd7, 1'b0, 2, 32'd21, 1'b1);
    run_and_check("b2b_mulhu", mk_insn(7'b0000001, 3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFE, 1'b1);
  endtask

  task automatic test_non_m();
    int act;
    act = 0;
    pcpi_insn = mk_insn(7'b0000000, 3'b000); pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd2; pcpi_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (mul_valid || div_valid || pcpi_wait || pcpi_ready) act++;
    end
    pcpi_valid = 1'b0;
    step();
    tot_cnt++; if (act !== 0) $display("FAIL non_m_activity got=%0d exp=0", act); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int vcyc, nrdy, wait_mis;
    logic [31:0] prev_rd;
    vcyc = 0; nrdy = 0; wait_mis = 0;
    prev_rd = pcpi_rd;
    pcpi_insn = mk_insn(7'b0000001, 3'b000); pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd9; pcpi_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      clear_stubs();
      if (mul_valid) vcyc++;
      if (pcpi_wait !== mul_valid) wait_mis++;
      if (pcpi_ready) nrdy++;
      if (c == 11) begin mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'hDEAD; end
    end
    tot_cnt++; if (vcyc !== 8) $display("FAIL timeout_valid_cycles got=%0d exp=8", vcyc); else pass_cnt++;
    tot_cnt++; if (wait_mis !== 0) $display("FAIL timeout_wait_tracks_valid got=%0d exp=0", wait_mis); else pass_cnt++;
    tot_cnt++; if (nrdy !== 0) $display("FAIL timeout_ready_pulses got=%0d exp=0", nrdy); else pass_cnt++;
    tot_cnt++; if (pcpi_rd !== prev_rd) $display("FAIL timeout_rd_hold got=%h exp=%h", pcpi_rd, prev_rd); else pass_cnt++;
    pcpi_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_ready_at_expiry();
    run_and_check("expiry", mk_insn(7'b0000001, 3'b001), 32'd5, 32'd6, 1'b0, 8, 32'h1234, 1'b1);
  endtask

  task automatic test_abort();
    int vcyc, nrdy, v_after;
    vcyc = 0; nrdy = 0; v_after = -1;
    pcpi_insn = mk_insn(7'b0000001, 3'b100); pcpi_rs1 = 32'd8; pcpi_rs2 = 32'd2; pcpi_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      clear_stubs();
      if (div_valid) vcyc++;
      if (pcpi_ready) nrdy++;
      if (v_after == -2) v_after = int'(div_valid);
      if (vcyc == 2 && pcpi_valid) begin pcpi_valid = 1'b0; v_after = -2; end
      if (c == 5) begin div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd4; end
    end
    tot_cnt++; if (v_after !== 0) $display("FAIL abort_valid_drop got=%0d exp=0", v_after); else pass_cnt++;
    tot_cnt++; if (nrdy !== 0) $display("FAIL abort_ready_pulses got=%0d exp=0", nrdy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int vcyc, nrdy;
    logic [4:0] flags;
    logic [31:0] rd_s, co_s;
    vcyc = 0; nrdy = 0; flags = '1; rd_s = '1; co_s = '1;
    pcpi_insn = mk_insn(7'b0000001, 3'b000); pcpi_rs1 = 32'd11; pcpi_rs2 = 32'd12; pcpi_valid = 1'b1;
    for (int c = 0; c < 10 && vcyc < 2; c++) begin
      step();
      if (mul_valid) vcyc++;
    end
    reset = 1'b1; pcpi_valid = 1'b0;
    step();
    flags = {pcpi_wr, pcpi_ready, pcpi_wait, mul_valid, div_valid};
    rd_s = pcpi_rd; co_s = co_insn | co_rs1 | co_rs2;
    reset = 1'b0;
    step();
    mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd132;
    for (int c = 0; c < 6; c++) begin
      step();
      clear_stubs();
      if (pcpi_ready || mul_valid) nrdy++;
    end
    tot_cnt++; if (flags !== 5'b0) $display("FAIL reset_mid_flags got=%b exp=00000", flags); else pass_cnt++;
    tot_cnt++; if ({rd_s, co_s} !== 64'd0) $display("FAIL reset_mid_data got=%h/%h exp=0/0", rd_s, co_s); else pass_cnt++;
    tot_cnt++; if (nrdy !== 0) $display("FAIL reset_mid_late_ready got=%0d exp=0", nrdy); else pass_cnt++;
  endtask

  task automatic test_recovery();
    run_and_check("recover_wr0", mk_insn(7'b0000001, 3'b000), 32'd5, 32'd6, 1'b0, 1, 32'd30, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    mul_rd = '0; div_rd = '0;
    clear_stubs();
    test_reset();
    test_mul();
    test_divu();
    test_back_to_back();
    test_non_m();
    test_timeout();
    test_ready_at_expiry();
    test_abort();
    test_reset_mid();
    test_recovery();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
